// File: rtl/instr_cache_refill_ctrl.sv
// Instruction-cache refill sequencer: line read on miss, beat-by-beat data array fill,
// tag install into a round-robin victim way, plus a full invalidate sweep on flush.
module instr_cache_refill_ctrl #(
    parameter int PADDR_WIDTH  = 32,
    parameter int ICACHE_ASSOC = 4,
    parameter int ICACHE_SETS  = 64,
    parameter int LINE_BYTES   = 32,
    parameter int BEAT_BYTES   = 8
) (
    input  logic                                   i_clk,
    input  logic                                   i_rst_n,
    input  logic                                   i_miss_valid,
    input  logic [PADDR_WIDTH-1:0]                 i_miss_paddr,
    output logic                                   o_miss_ready,
    input  logic                                   i_flush,
    output logic                                   o_mem_req_valid,
    output logic [PADDR_WIDTH-1:0]                 o_mem_req_paddr,
    input  logic                                   i_mem_req_ready,
    input  logic                                   i_mem_resp_valid,
    input  logic [8*BEAT_BYTES-1:0]                i_mem_resp_data,
    output logic                                   o_data_we,
    output logic [$clog2(ICACHE_ASSOC)-1:0]        o_data_way,
    output logic [$clog2(ICACHE_SETS)-1:0]         o_data_set,
    output logic [$clog2(LINE_BYTES/BEAT_BYTES)-1:0] o_data_beat,
    output logic [8*BEAT_BYTES-1:0]                o_data_wdata,
    output logic                                   o_tag_we,
    output logic [$clog2(ICACHE_ASSOC)-1:0]        o_tag_way,
    output logic [$clog2(ICACHE_SETS)-1:0]         o_tag_set,
    output logic                                   o_tag_valid,
    output logic [PADDR_WIDTH-$clog2(ICACHE_SETS)-$clog2(LINE_BYTES)-1:0] o_tag_value,
    output logic                                   o_refill_done,
    output logic                                   o_busy
);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int SET_W  = $clog2(ICACHE_SETS);
    localparam int WAY_W  = $clog2(ICACHE_ASSOC);
    localparam int BEATS  = LINE_BYTES / BEAT_BYTES;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int LINE_W = PADDR_WIDTH - OFF_W;

    localparam logic [WAY_W-1:0]  LAST_WAY  = WAY_W'(ICACHE_ASSOC - 1);
    localparam logic [SET_W-1:0]  LAST_SET  = SET_W'(ICACHE_SETS - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_FILL  = 3'd2;
    localparam logic [2:0] S_TAG   = 3'd3;
    localparam logic [2:0] S_FLUSH = 3'd4;

    logic [2:0]        state_q,  state_d;
    logic [WAY_W-1:0]  victim_q, victim_d;
    logic [BEAT_W-1:0] beat_q,   beat_d;
    logic [SET_W-1:0]  fl_set_q, fl_set_d;
    logic [WAY_W-1:0]  fl_way_q, fl_way_d;
    logic [LINE_W-1:0] line_q,   line_d;

    // Only the line address is kept; the byte offset of the miss is never needed.
    logic unused_paddr_off;
    assign unused_paddr_off = ^i_miss_paddr[OFF_W-1:0];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            victim_q <= '0;
            beat_q   <= '0;
            fl_set_q <= '0;
            fl_way_q <= '0;
            line_q   <= '0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
            beat_q   <= beat_d;
            fl_set_q <= fl_set_d;
            fl_way_q <= fl_way_d;
            line_q   <= line_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        victim_d        = victim_q;
        beat_d          = beat_q;
        fl_set_d        = fl_set_q;
        fl_way_d        = fl_way_q;
        line_d          = line_q;
        o_miss_ready    = 1'b0;
        o_mem_req_valid = 1'b0;
        o_mem_req_paddr = '0;
        o_data_we       = 1'b0;
        o_data_way      = '0;
        o_data_set      = '0;
        o_data_beat     = '0;
        o_data_wdata    = '0;
        o_tag_we        = 1'b0;
        o_tag_way       = '0;
        o_tag_set       = '0;
        o_tag_valid     = 1'b0;
        o_tag_value     = '0;
        o_refill_done   = 1'b0;
        o_busy          = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                // Held low during reset so every output reads zero while reset is applied.
                o_miss_ready = i_rst_n & ~i_flush;
                if (i_flush) begin
                    state_d  = S_FLUSH;
                    fl_set_d = '0;
                    fl_way_d = '0;
                end else if (i_miss_valid) begin
                    line_d  = i_miss_paddr[PADDR_WIDTH-1:OFF_W];
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                o_mem_req_valid = 1'b1;
                o_mem_req_paddr = {line_q, {OFF_W{1'b0}}};
                if (i_mem_req_ready) begin
                    state_d = S_FILL;
                    beat_d  = '0;
                end
            end
            S_FILL: begin
                if (i_mem_resp_valid) begin
                    o_data_we    = 1'b1;
                    o_data_way   = victim_q;
                    o_data_set   = line_q[SET_W-1:0];
                    o_data_beat  = beat_q;
                    o_data_wdata = i_mem_resp_data;
                    beat_d       = beat_q + BEAT_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_TAG;
                    end
                end
            end
            S_TAG: begin
                o_tag_we      = 1'b1;
                o_tag_way     = victim_q;
                o_tag_set     = line_q[SET_W-1:0];
                o_tag_valid   = 1'b1;
                o_tag_value   = line_q[LINE_W-1:SET_W];
                o_refill_done = 1'b1;
                victim_d      = victim_q + WAY_W'(1);
                state_d       = S_IDLE;
            end
            S_FLUSH: begin
                o_tag_we  = 1'b1;
                o_tag_set = fl_set_q;
                o_tag_way = fl_way_q;
                if (fl_way_q == LAST_WAY) begin
                    fl_way_d = '0;
                    if (fl_set_q == LAST_SET) begin
                        fl_set_d = '0;
                        victim_d = '0;
                        state_d  = S_IDLE;
                    end else begin
                        fl_set_d = fl_set_q + SET_W'(1);
                    end
                end else begin
                    fl_way_d = fl_way_q + WAY_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule
